// File: rtl/norm_iter_pkg.sv
// rtl/norm_iter_pkg.sv - shared FP-utility types and helpers for the normalizer
package norm_iter_pkg;

  // Normalizer control states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } norm_state_t;

  // Bits needed to hold a zero count in the range 0..w
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/norm_iter_if.sv
// rtl/norm_iter_if.sv - operand/result handshake bundle for the normalizer
interface norm_iter_if #(
  parameter int WIDTH = 23
);
  localparam int CW = norm_iter_pkg::cnt_width(WIDTH);

  logic             InValid;
  logic             InReady;
  logic [WIDTH-1:0] InNum;
  logic             OutValid;
  logic             OutReady;
  logic [WIDTH-1:0] OutNorm;
  logic [CW-1:0]    OutCnt;
  logic             OutZero;

  // Producer/consumer side (drives operands, accepts results)
  modport master (
    output InValid, InNum, OutReady,
    input  InReady, OutValid, OutNorm, OutCnt, OutZero
  );

  // Normalizer side
  modport slave (
    input  InValid, InNum, OutReady,
    output InReady, OutValid, OutNorm, OutCnt, OutZero
  );
endinterface

// File: rtl/lzc.sv
// rtl/lzc.sv - combinational leading-zero counter
module lzc #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0]                            i_data,
  output logic [norm_iter_pkg::cnt_width(WIDTH)-1:0]  o_cnt
);
  localparam int CW = norm_iter_pkg::cnt_width(WIDTH);

  logic w_found;

  // Scan from the MSB; the first set bit fixes the count, all-zero yields WIDTH
  always_comb begin
    o_cnt   = CW'(WIDTH);
    w_found = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!w_found && i_data[i]) begin
        o_cnt   = CW'(WIDTH - 1 - i);
        w_found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/norm_iter.sv
// rtl/norm_iter.sv - multi-cycle mantissa normalizer with bounded shift per cycle
module norm_iter
  import norm_iter_pkg::*;
#(
  parameter int WIDTH = 23,
  parameter int STEP  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Flush,
  norm_iter_if.slave  bus
);
  localparam int CW = cnt_width(WIDTH);
  localparam int SW = cnt_width(STEP);

  norm_state_t      r_state;
  logic [WIDTH-1:0] r_work;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_cap;
  logic [WIDTH-1:0] r_norm;
  logic [CW-1:0]    r_out_cnt;
  logic             r_zero;

  logic [STEP-1:0]  w_win;
  logic [SW-1:0]    w_z;
  logic             w_full;

  // Only the top STEP bits are inspected each cycle, keeping the shifter narrow
  assign w_win  = r_work[WIDTH-1 -: STEP];
  assign w_full = (w_z == SW'(STEP));

  lzc #(
    .WIDTH (STEP)
  ) u_lzc (
    .i_data (w_win),
    .o_cnt  (w_z)
  );

  assign bus.InReady  = (r_state == IDLE);
  assign bus.OutValid = (r_state == DONE);
  assign bus.OutNorm  = r_norm;
  assign bus.OutCnt   = r_out_cnt;
  assign bus.OutZero  = r_zero;

  // Control FSM with shifter and count; Flush aborts like reset
  always_ff @(posedge clk) begin
    if (reset || Flush) begin
      r_state   <= IDLE;
      r_work    <= '0;
      r_cnt     <= '0;
      r_cap     <= '0;
      r_norm    <= '0;
      r_out_cnt <= '0;
      r_zero    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.InValid) begin
            r_work <= bus.InNum;
            r_cap  <= bus.InNum;
            r_cnt  <= '0;
            if (bus.InNum == '0) begin
              r_state   <= DONE;
              r_zero    <= 1'b1;
              r_norm    <= '0;
              r_out_cnt <= CW'(WIDTH);
            end else begin
              r_state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          if (w_full) begin
            r_work <= r_work << STEP;
            r_cnt  <= r_cnt + CW'(STEP);
          end else begin
            r_work    <= r_work << w_z;
            r_cnt     <= r_cnt + CW'(w_z);
            r_norm    <= r_work << w_z;
            r_out_cnt <= r_cnt + CW'(w_z);
            r_state   <= DONE;
          end
        end
        DONE: begin
          if (bus.OutReady) begin
            r_state   <= IDLE;
            r_work    <= '0;
            r_cnt     <= '0;
            r_norm    <= '0;
            r_out_cnt <= '0;
            r_zero    <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Result sanity: normalized MSB set and result consistent with captured operand
  always_ff @(posedge clk) begin
    if (!reset && bus.OutValid && !bus.OutZero) begin
      assert (bus.OutNorm[WIDTH-1]);
      assert (bus.OutNorm == (r_cap << bus.OutCnt));
    end
  end
endmodule
